multi_pulse_generator: RTL and testbench

Multi-channel successor to the single-channel periodic pulse generator. Each channel runs its own programmable period and high-time, in continuous or one-shot mode. Used to produce sample strobes, PWM-style enables and timed gating for the sigma-delta DAC datapath. Period and width changes are shadowed and take effect only at a period boundary, so no glitch or runt pulse appears on the output.

---
 rtl/multi_pulse_generator.sv | 68 ++++++
 tb/tb_multi_pulse_generator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_generator.sv
// Independent per-channel periodic/one-shot pulse generators with period/width shadowed to period boundaries.
// Latency: first out/wrap cycle one clk after enable or start; no flow control, ena freezes all state.
module multi_pulse_generator #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [CHANNELS-1:0]   ch_ena,
  input  logic [CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]   start,
  input  logic [CHANNELS*N-1:0] ticks,
  input  logic [CHANNELS*N-1:0] width,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   wrap,
  output logic [CHANNELS-1:0]   busy
);

  typedef enum logic {IDLE, RUN} state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t         state;
    logic [N-1:0]   counter;
    logic [N-1:0]   tk_s;
    logic [N-1:0]   wd_s;
    logic           mode_s;

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        counter <= '0;
        tk_s    <= '0;
        wd_s    <= '0;
        mode_s  <= 1'b0;
      end else if (ena) begin
        if (!ch_ena[c]) begin
          state   <= IDLE;
          counter <= '0;
        end else if (state == IDLE) begin
          if (!mode[c] || start[c]) begin
            state   <= RUN;
            counter <= '0;
            tk_s    <= ticks[c*N +: N];
            wd_s    <= width[c*N +: N];
            mode_s  <= mode[c];
          end
        end else if (counter != tk_s) begin
          counter <= counter + N'(1);
        end else if (!mode_s) begin
          // Period boundary: the only point where new settings are adopted.
          counter <= '0;
          tk_s    <= ticks[c*N +: N];
          wd_s    <= width[c*N +: N];
          mode_s  <= mode[c];
        end else begin
          state   <= IDLE;
          counter <= '0;
        end
      end
    end

    assign busy[c] = (state == RUN);
    assign out[c]  = (state == RUN) && (counter < wd_s);
    assign wrap[c] = (state == RUN) && (counter == tk_s);
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Scoreboard bench for multi_pulse_generator: a behavioural model predicts outputs each edge.
module tb_multi_pulse_generator;
  localparam int N  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst, ena;
  logic [CH-1:0]   ch_ena, mode, start;
  logic [CH*N-1:0] ticks, width;
  logic [CH-1:0]   out, wrap, busy;

  multi_pulse_generator #(.N(N), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ch_ena(ch_ena), .mode(mode), .start(start),
    .ticks(ticks), .width(width), .out(out), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  bit           m_run [CH];
  logic [N-1:0] m_cnt [CH];
  logic [N-1:0] m_tk  [CH];
  logic [N-1:0] m_wd  [CH];
  bit           m_md  [CH];

  logic [3*CH-1:0] sb_q[$];
  int n_out [CH];
  int n_wrap[CH];
  int n_busy[CH];

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_run[c] = 0; m_cnt[c] = '0; m_tk[c] = '0; m_wd[c] = '0; m_md[c] = 0;
      end else if (ena) begin
        if (!ch_ena[c]) begin
          m_run[c] = 0; m_cnt[c] = '0;
        end else if (!m_run[c]) begin
          if (!mode[c] || start[c]) begin
            m_run[c] = 1; m_cnt[c] = '0;
            m_tk[c] = ticks[c*N +: N]; m_wd[c] = width[c*N +: N]; m_md[c] = mode[c];
          end
        end else if (m_cnt[c] < m_tk[c]) begin
          m_cnt[c] = m_cnt[c] + 1'b1;
        end else if (m_md[c]) begin
          m_run[c] = 0; m_cnt[c] = '0;
        end else begin
          m_cnt[c] = '0;
          m_tk[c] = ticks[c*N +: N]; m_wd[c] = width[c*N +: N]; m_md[c] = mode[c];
        end
      end
    end
  endtask

  function automatic logic [3*CH-1:0] model_outputs();
    logic [CH-1:0] eo, ew, eb;
    eo = '0; ew = '0; eb = '0;
    for (int c = 0; c < CH; c++) begin
      eb[c] = m_run[c];
      eo[c] = m_run[c] && (int'(m_cnt[c]) < int'(m_wd[c]));
      ew[c] = m_run[c] && (m_cnt[c] == m_tk[c]);
    end
    return {eo, ew, eb};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    sb_q.push_back(model_outputs());
    #1;
    check("sb_out_wrap_busy", {out, wrap, busy}, sb_q.pop_front());
    for (int c = 0; c < CH; c++) begin
      n_out[c]  += int'(out[c]);
      n_wrap[c] += int'(wrap[c]);
      n_busy[c] += int'(busy[c]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_counts();
    for (int c = 0; c < CH; c++) begin
      n_out[c] = 0; n_wrap[c] = 0; n_busy[c] = 0;
    end
  endtask

  task automatic set_ch(input int c, input int tk, input int wd, input bit md);
    ticks[c*N +: N] = N'(tk);
    width[c*N +: N] = N'(wd);
    mode[c]         = md;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; ch_ena = '0; mode = '0; start = '0; ticks = '0; width = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_cnt[c] = '0; m_tk[c] = '0; m_wd[c] = '0; m_md[c] = 0;
    end
    clr_counts();

    // reset and idle
    run(2);
    check("reset_outputs", {out, wrap, busy}, 0);
    rst = 1'b0;
    clr_counts();
    run(20);
    check("idle_busy_cnt", n_busy[0] + n_busy[1] + n_busy[2] + n_busy[3], 0);
    check("idle_out_cnt", n_out[0] + n_out[1] + n_out[2] + n_out[3], 0);

    // continuous ch0: ticks=4 width=2, ten periods
    set_ch(0, 4, 2, 0);
    ch_ena[0] = 1'b1;
    clr_counts();
    cycle();
    check("ch0_busy_rise", busy[0], 1);
    check("ch0_first_out", out[0], 1);
    run(49);
    check("ch0_out_10per", n_out[0], 20);
    check("ch0_wrap_10per", n_wrap[0], 10);

    // shadow reload: change settings on 2nd cycle of a period
    clr_counts();
    cycle();
    set_ch(0, 9, 7, 0);
    run(4);
    check("shadow_cur_out", n_out[0], 2);
    check("shadow_cur_wrap", n_wrap[0], 1);
    clr_counts();
    run(10);
    check("shadow_next_out", n_out[0], 7);
    check("shadow_next_wrap", n_wrap[0], 1);

    // one-shot ch1: single start, start during RUN ignored
    set_ch(1, 3, 1, 1);
    ch_ena[1] = 1'b1;
    clr_counts();
    start[1] = 1'b1; cycle();
    start[1] = 1'b0; cycle();
    start[1] = 1'b1; cycle();
    start[1] = 1'b0; run(5);
    check("oneshot_busy", n_busy[1], 4);
    check("oneshot_out", n_out[1], 1);
    check("oneshot_wrap", n_wrap[1], 1);
    check("oneshot_idle", busy[1], 0);
    // held start: 4 busy + 1 gap, twice
    clr_counts();
    start[1] = 1'b1; run(10);
    check("held_busy", n_busy[1], 8);
    check("held_wrap", n_wrap[1], 2);
    start[1] = 1'b0; run(5);

    // edge values on ch2 and ch3
    set_ch(2, 0, 0, 0);
    ch_ena[2] = 1'b1;
    clr_counts();
    run(6);
    check("t0w0_wrap", n_wrap[2], 6);
    check("t0w0_out", n_out[2], 0);
    set_ch(2, 0, 1, 0);
    run(1);
    clr_counts();
    run(6);
    check("t0w1_out", n_out[2], 6);
    set_ch(3, 255, 255, 0);
    ch_ena[3] = 1'b1;
    clr_counts();
    run(256);
    check("t255_out", n_out[3], 255);
    check("t255_wrap", n_wrap[3], 1);
    check("t255_last_wrap", wrap[3], 1);
    check("t255_last_out", out[3], 0);

    // freeze, per-channel abort, reset mid-period
    run(3);
    ena = 1'b0;
    clr_counts();
    run(7);
    check("freeze_ch3_busy", n_busy[3], 7);
    check("freeze_ch2_wrap", n_wrap[2], 7);
    ena = 1'b1;
    run(12);
    ch_ena[0] = 1'b0;
    cycle();
    check("abort_ch0_busy", busy[0], 0);
    check("abort_others_busy", busy[3:2], 2'b11);
    run(3);
    rst = 1'b1;
    cycle();
    check("rst_mid_outputs", {out, wrap, busy}, 0);
    rst = 1'b0;
    ch_ena = '0;
    run(4);

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
